// File: rtl/riscv_ctrl_pkg.sv
// Shared control-bundle types and opcode constants for the RV32I core.
package riscv_ctrl_pkg;

  // Decoder control bundle, MSB..LSB as listed.
  typedef struct packed {
    logic jalr;
    logic jal;
    logic branch;
    logic memread;
    logic memtoreg;
    logic memwrite;
    logic alusrc;
    logic regwrite;
  } ctrl_t;

  localparam int    CTRL_BITS = $bits(ctrl_t);
  localparam ctrl_t CTRL_NOP  = '0;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Source-operand usage derived from the control bundle.
  function automatic logic ctrl_uses_rs1(input ctrl_t c);
    return !c.jal;
  endfunction

  function automatic logic ctrl_uses_rs2(input ctrl_t c);
    return (!c.alusrc && !c.jal) || c.memwrite;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard detection: the instruction in EX is a load whose rd feeds
// an operand that the ID instruction actually reads.
module hazard_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic [7:0]        ex_ctrl_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              id_valid_i,
  input  logic [7:0]        id_ctrl_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  output logic              uses_rs1_o,
  output logic              uses_rs2_o,
  output logic              load_use_o
);

  ctrl_t ex_c, id_c;
  logic  rs1_hit, rs2_hit;

  assign ex_c = ctrl_t'(ex_ctrl_i);
  assign id_c = ctrl_t'(id_ctrl_i);

  // Operand usage and register match against the load's destination.
  always_comb begin
    uses_rs1_o = ctrl_uses_rs1(id_c);
    uses_rs2_o = ctrl_uses_rs2(id_c);
    rs1_hit    = uses_rs1_o && (ex_rd_i == id_rs1_i);
    rs2_hit    = uses_rs2_o && (ex_rd_i == id_rs2_i);
    // x0 never carries a hazard: writes to it are discarded.
    load_use_o = ex_valid_i && ex_c.memread && (ex_rd_i != '0) && id_valid_i &&
                 (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion, EX-redirect flush
// and whole-pipe freeze on cache stall.
// Optional feature: define PERF_CNT_EN to add saturating load-use / flush
// event counters (perf_loaduse_cnt, perf_flush_cnt).
module id_ex_stage
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              flush_ex,
  input  logic              mem_stall,
  output logic              stall_if_id,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       perf_loaduse_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  logic              ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]   ex_pc_q, ex_pc_d;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]   ex_imm_q, ex_imm_d;

  logic uses_rs1, uses_rs2, load_use;
  logic bubble;

  hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid_i (ex_valid_q),
    .ex_ctrl_i  (ex_ctrl_q[7:0]),
    .ex_rd_i    (ex_rd_q),
    .id_valid_i (id_valid),
    .id_ctrl_i  (id_ctrl[7:0]),
    .id_rs1_i   (id_rs1),
    .id_rs2_i   (id_rs2),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2),
    .load_use_o (load_use)
  );

  // IF/ID hold: freeze on cache stall; load-use hold unless the ID slot is
  // being flushed anyway. EX regs are undefined in the first reset cycle,
  // so the hazard term is masked during reset.
  assign stall_if_id = mem_stall | (!rst & load_use & !flush_ex);

  // Next EX contents: a copy of ID or an all-zero bubble.
  always_comb begin
    bubble        = flush_ex | load_use | !id_valid;
    ex_valid_d    = 1'b0;
    ex_pc_d       = '0;
    ex_rs1_d      = '0;
    ex_rs2_d      = '0;
    ex_rd_d       = '0;
    ex_ctrl_d     = '0;
    ex_rs1_data_d = '0;
    ex_rs2_data_d = '0;
    ex_imm_d      = '0;
    if (!bubble) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = id_pc;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      ex_rd_d       = id_rd;
      ex_ctrl_d     = id_ctrl;
      ex_rs1_data_d = id_rs1_data;
      ex_rs2_data_d = id_rs2_data;
      ex_imm_d      = id_imm;
    end
  end

  // EX register bank: reset clears, mem_stall holds, otherwise load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_ctrl_q     <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
    end else if (!mem_stall) begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_imm      = ex_imm_q;

`ifdef PERF_CNT_EN
  logic [31:0] perf_loaduse_cnt_q, perf_loaduse_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;
  logic        lu_evt, fl_evt;

  // Events mirror the bubble priority: a frozen edge inserts nothing, and a
  // flush swallows a concurrent load-use.
  always_comb begin
    lu_evt             = !mem_stall & !flush_ex & load_use;
    fl_evt             = !mem_stall & flush_ex;
    perf_loaduse_cnt_d = perf_loaduse_cnt_q;
    perf_flush_cnt_d   = perf_flush_cnt_q;
    if (lu_evt && (perf_loaduse_cnt_q != 32'hFFFF_FFFF))
      perf_loaduse_cnt_d = perf_loaduse_cnt_q + 32'd1;
    if (fl_evt && (perf_flush_cnt_q != 32'hFFFF_FFFF))
      perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loaduse_cnt_q <= '0;
      perf_flush_cnt_q   <= '0;
    end else begin
      perf_loaduse_cnt_q <= perf_loaduse_cnt_d;
      perf_flush_cnt_q   <= perf_flush_cnt_d;
    end
  end

  assign perf_loaduse_cnt = perf_loaduse_cnt_q;
  assign perf_flush_cnt   = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use bubble, hazard exemptions,
// flush priority, mem_stall freeze and (with PERF_CNT_EN) counter saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [7:0]  id_ctrl;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        flush_ex, mem_stall;
  logic        stall_if_id, ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
`ifdef PERF_CNT_EN
  logic [31:0] perf_loaduse_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .flush_ex(flush_ex), .mem_stall(mem_stall), .stall_if_id(stall_if_id),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm)
`ifdef PERF_CNT_EN
    , .perf_loaduse_cnt(perf_loaduse_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; return 1ns after it so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctrl);
    id_valid    = v;
    id_pc       = pc;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_ctrl     = ctrl;
    id_rs1_data = pc ^ 32'hA5A5_0000;
    id_rs2_data = pc ^ 32'h0000_5A5A;
    id_imm      = pc + 32'd4;
  endtask

  localparam logic [7:0] C_LW  = 8'h1B; // memread|memtoreg|alusrc|regwrite
  localparam logic [7:0] C_ADD = 8'h01;
  localparam logic [7:0] C_JAL = 8'h41;
  localparam logic [7:0] C_SW  = 8'h06;

  initial begin
    // 1: reset with valid ID and mem_stall asserted
    rst = 1'b1; flush_ex = 1'b0; mem_stall = 1'b1;
    drive(1'b1, 32'h0000_0123, 5'd1, 5'd2, 5'd3, C_ADD);
    tick();
    tick();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_ctrl", {24'd0, ex_ctrl}, 32'd0);
    chk("rst_rd", {27'd0, ex_rd}, 32'd0);
    chk("rst_data", ex_rs1_data | ex_rs2_data | ex_imm, 32'd0);
    chk("rst_stall", {31'd0, stall_if_id}, 32'd1);
    mem_stall = 1'b0;
    #1;
    chk("rst_nostall", {31'd0, stall_if_id}, 32'd0);
    tick();
    rst = 1'b0;

    // 2: lw x5 then add x6,x5,x7 -> one bubble then issue
    drive(1'b1, 32'h10, 5'd2, 5'd0, 5'd5, C_LW);
    tick();
    chk("lw_in_ex", {24'd0, ex_ctrl}, {24'd0, C_LW});
    drive(1'b1, 32'h14, 5'd5, 5'd7, 5'd6, C_ADD);
    #1;
    chk("lu_stall", {31'd0, stall_if_id}, 32'd1);
    tick();
    chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bub_ctrl", {24'd0, ex_ctrl}, 32'd0);
    chk("lu_bub_rd", {27'd0, ex_rd}, 32'd0);
    chk("lu_bub_pc", ex_pc, 32'd0);
    chk("lu_restall", {31'd0, stall_if_id}, 32'd0);
    tick();
    chk("lu_issue_rd", {27'd0, ex_rd}, 32'd6);
    chk("lu_issue_ctrl", {24'd0, ex_ctrl}, {24'd0, C_ADD});
    chk("lu_issue_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_issue_pc", ex_pc, 32'h14);
    chk("lu_issue_d1", ex_rs1_data, 32'hA5A5_0014);
    chk("lu_issue_d2", ex_rs2_data, 32'h0000_5A4E);
    chk("lu_issue_imm", ex_imm, 32'h18);
    chk("lu_issue_rs", {22'd0, ex_rs1, ex_rs2}, {22'd0, 5'd5, 5'd7});
`ifdef PERF_CNT_EN
    chk("perf_lu_1", perf_loaduse_cnt, 32'd1);
`endif

    // 3a: lw x0 followed by a reader of x0 -> no stall
    drive(1'b1, 32'h20, 5'd1, 5'd0, 5'd0, C_LW);
    tick();
    drive(1'b1, 32'h24, 5'd0, 5'd3, 5'd8, C_ADD);
    #1;
    chk("x0_nostall", {31'd0, stall_if_id}, 32'd0);
    // 3b: lw x5 followed by jal whose rs fields alias x5 -> no stall
    drive(1'b1, 32'h28, 5'd1, 5'd0, 5'd5, C_LW);
    tick();
    drive(1'b1, 32'h2C, 5'd5, 5'd5, 5'd1, C_JAL);
    #1;
    chk("jal_nostall", {31'd0, stall_if_id}, 32'd0);
    tick();
    chk("jal_issue", {23'd0, ex_valid, ex_ctrl}, {23'd0, 1'b1, C_JAL});

    // 4: lw x5 then sw x5,0(x9): stall via rs2; with flush: no stall, bubble
    drive(1'b1, 32'h30, 5'd1, 5'd0, 5'd5, C_LW);
    tick();
    drive(1'b1, 32'h34, 5'd9, 5'd5, 5'd0, C_SW);
    #1;
    chk("sw_stall", {31'd0, stall_if_id}, 32'd1);
    flush_ex = 1'b1;
    #1;
    chk("flush_nostall", {31'd0, stall_if_id}, 32'd0);
    tick();
    flush_ex = 1'b0;
    chk("flush_bub", {23'd0, ex_valid, ex_ctrl}, 32'd0);
    chk("flush_bub_pc", ex_pc, 32'd0);
`ifdef PERF_CNT_EN
    chk("perf_fl_1", perf_flush_cnt, 32'd1);
    chk("perf_lu_keep", perf_loaduse_cnt, 32'd1);
`endif

    // 5: mem_stall freeze for 3 cycles, then release issues new ID
    drive(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, C_ADD);
    tick();
    chk("pre_frz_pc", ex_pc, 32'h40);
    drive(1'b1, 32'h80, 5'd1, 5'd2, 5'd4, C_ADD);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_stall", {31'd0, stall_if_id}, 32'd1);
      tick();
      chk("frz_pc", ex_pc, 32'h40);
      chk("frz_rd", {27'd0, ex_rd}, 32'd3);
    end
    mem_stall = 1'b0;
    tick();
    chk("rel_pc", ex_pc, 32'h80);
    chk("rel_rd", {27'd0, ex_rd}, 32'd4);

    // mem_stall beats a concurrent load-use: EX holds the load, no counting
    drive(1'b1, 32'h90, 5'd1, 5'd0, 5'd5, C_LW);
    tick();
    drive(1'b1, 32'h94, 5'd5, 5'd0, 5'd6, C_ADD);
    mem_stall = 1'b1;
    tick();
    chk("stall_lu_hold", {23'd0, ex_valid, ex_ctrl}, {23'd0, 1'b1, C_LW});
`ifdef PERF_CNT_EN
    chk("perf_lu_frz", perf_loaduse_cnt, 32'd1);
`endif
    mem_stall = 1'b0;
    tick();
    chk("stall_lu_bub", {31'd0, ex_valid}, 32'd0);

    // id_valid=0 -> bubble; all-zero ctrl with valid -> harmless valid no-op
    drive(1'b0, 32'hA0, 5'd1, 5'd2, 5'd3, C_ADD);
    tick();
    chk("inv_bub", {23'd0, ex_valid, ex_ctrl}, 32'd0);
    chk("inv_bub_rd", {27'd0, ex_rd}, 32'd0);
    drive(1'b1, 32'hA4, 5'd1, 5'd2, 5'd3, 8'h00);
    tick();
    chk("nop_valid", {23'd0, ex_valid, ex_ctrl}, {23'd0, 1'b1, 8'h00});
    chk("nop_pc", ex_pc, 32'hA4);

`ifdef PERF_CNT_EN
    // 6: flush counter saturates
    force dut.perf_flush_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.perf_flush_cnt_q;
    flush_ex = 1'b1;
    tick();
    chk("perf_sat_1", perf_flush_cnt, 32'hFFFF_FFFF);
    tick();
    chk("perf_sat_2", perf_flush_cnt, 32'hFFFF_FFFF);
    flush_ex = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
